mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter with starvation guard and slave timeout.
// One transaction at a time: arbitrate in IDLE, drive the slave in BUSY,
// present the registered ack/err/rdata to the owner in DONE.
//
//   state | meaning
//   IDLE  | no owner; arbitrate between pending requests
//   BUSY  | slave request active for the latched owner
//   DONE  | owner's ack or err pulse (and read data) visible
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byte_mask,
  input  logic        m0_load_sign,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byte_mask,
  input  logic        m1_load_sign,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        s_req_o,
  output logic        s_rw_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_be_o,
  input  logic        s_ack,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    WAIT_MAX   = 4'(TIMEOUT);

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [3:0]    wait_cnt;
  logic          load_sign_q;

  logic          pick_m1;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_mask;
  logic          sel_sign;
  logic [31:0]   fmt_rdata;

  // Sub-word loads are right-aligned; upper bits are zero or sign copies.
  function automatic logic [31:0] format_rdata(input logic [3:0] mask,
                                               input logic sign,
                                               input logic [31:0] data);
    logic [31:0] res;
    res = '0;
    case (mask)
      4'b1111: res = data;
      4'b0011: res = {{16{sign & data[15]}}, data[15:0]};
      4'b0001: res = {{24{sign & data[7]}}, data[7:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Arbitration decision and field mux for the candidate owner.
  always_comb begin
    pick_m1   = !m0_req || (m1_req && (starve_cnt == STARVE_MAX));
    sel_we    = pick_m1 ? m1_we        : m0_we;
    sel_addr  = pick_m1 ? m1_addr      : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata     : m0_wdata;
    sel_mask  = pick_m1 ? m1_byte_mask : m0_byte_mask;
    sel_sign  = pick_m1 ? m1_load_sign : m0_load_sign;
    fmt_rdata = s_rw_o ? 32'd0 : format_rdata(s_be_o, load_sign_q, s_rdata);
  end

  // Transaction FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      load_sign_q <= 1'b0;
      grant_o     <= 2'b00;
      s_req_o     <= 1'b0;
      s_rw_o      <= 1'b0;
      s_addr_o    <= '0;
      s_wdata_o   <= '0;
      s_be_o      <= '0;
      m0_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      m1_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state       <= BUSY;
            wait_cnt    <= '0;
            grant_o     <= pick_m1 ? 2'b10 : 2'b01;
            s_req_o     <= 1'b1;
            s_rw_o      <= sel_we;
            s_addr_o    <= sel_addr;
            s_wdata_o   <= sel_wdata;
            s_be_o      <= sel_mask;
            load_sign_q <= sel_sign;
            if (pick_m1 || !m1_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        BUSY: begin
          if (s_ack) begin
            state   <= DONE;
            s_req_o <= 1'b0;
            if (grant_o[0]) begin
              m0_ack   <= 1'b1;
              m0_rdata <= fmt_rdata;
            end
            if (grant_o[1]) begin
              m1_ack   <= 1'b1;
              m1_rdata <= fmt_rdata;
            end
          end else if (wait_cnt == WAIT_MAX) begin
            state   <= DONE;
            s_req_o <= 1'b0;
            m0_err  <= grant_o[0];
            m1_err  <= grant_o[1];
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          grant_o  <= 2'b00;
          m0_ack   <= 1'b0;
          m0_err   <= 1'b0;
          m0_rdata <= '0;
          m1_ack   <= 1'b0;
          m1_err   <= 1'b0;
          m1_rdata <= '0;
        end
        default: begin
          state   <= IDLE;
          s_req_o <= 1'b0;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, read formatting, writes, starvation
// rotation, slave timeout and reset during BUSY.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_load_sign;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_byte_mask;
  logic        m1_req, m1_we, m1_load_sign;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_byte_mask;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req_o, s_rw_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic [1:0]  grant_o;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_byte_mask(m0_byte_mask), .m0_load_sign(m0_load_sign),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_byte_mask(m1_byte_mask), .m1_load_sign(m1_load_sign),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req_o(s_req_o), .s_rw_o(s_rw_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sreq"}, {31'd0, s_req_o}, 32'd0);
    check({tag, "_grant"}, {30'd0, grant_o}, 32'd0);
    check({tag, "_acks"}, {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    check({tag, "_m0rd"}, m0_rdata, 32'd0);
    check({tag, "_m1rd"}, m1_rdata, 32'd0);
    check({tag, "_saddr"}, s_addr_o, 32'd0);
    check({tag, "_swdata"}, s_wdata_o, 32'd0);
    check({tag, "_sbe_rw"}, {27'd0, s_rw_o, s_be_o}, 32'd0);
  endtask

  // Single-master transaction with immediate slave ack.
  task automatic xact(input string tag, input int m, input logic we,
                      input logic [3:0] mask, input logic sign,
                      input logic [31:0] sdata, input logic [31:0] exp_rd);
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_byte_mask = mask; m0_load_sign = sign;
      m0_addr = 32'h0000_0400; m0_wdata = 32'h1111_2222;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_byte_mask = mask; m1_load_sign = sign;
      m1_addr = 32'h0000_0800; m1_wdata = 32'h3333_4444;
    end
    tick();
    check({tag, "_grant"}, {30'd0, grant_o}, (m == 0) ? 32'd1 : 32'd2);
    check({tag, "_be"}, {28'd0, s_be_o}, {28'd0, mask});
    s_ack = 1'b1; s_rdata = sdata;
    tick();
    if (m == 0) begin
      check({tag, "_ack"}, {31'd0, m0_ack}, 32'd1);
      check({tag, "_rdata"}, m0_rdata, exp_rd);
      check({tag, "_other"}, {31'd0, m1_ack} | m1_rdata, 32'd0);
    end else begin
      check({tag, "_ack"}, {31'd0, m1_ack}, 32'd1);
      check({tag, "_rdata"}, m1_rdata, exp_rd);
      check({tag, "_other"}, {31'd0, m0_ack} | m0_rdata, 32'd0);
    end
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0; s_rdata = 32'd0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_byte_mask = 0; m0_load_sign = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_byte_mask = 0; m1_load_sign = 0;
    s_ack = 0; s_rdata = 0;
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // m0 word read, slave acks one cycle after s_req_o rises.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_byte_mask = 4'hF;
    tick();
    check("rd_sreq", {31'd0, s_req_o}, 32'd1);
    check("rd_grant", {30'd0, grant_o}, 32'd1);
    check("rd_addr", s_addr_o, 32'h100);
    check("rd_rw", {31'd0, s_rw_o}, 32'd0);
    s_ack = 1'b0;   // s_ack outside its cycle is absent
    tick();
    check("rd_wait_noack", {31'd0, m0_ack}, 32'd0);
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    tick();
    check("rd_ack", {31'd0, m0_ack}, 32'd1);
    check("rd_data", m0_rdata, 32'hDEADBEEF);
    check("rd_m1quiet", {30'd0, m1_ack, m1_err} | m1_rdata, 32'd0);
    check("rd_done_sreq", {31'd0, s_req_o}, 32'd0);
    m0_req = 1'b0;   // s_ack stays high: must be ignored in IDLE/DONE
    tick();
    check("rd_idle_ack", {31'd0, m0_ack}, 32'd0);
    check("rd_idle_rdata", m0_rdata, 32'd0);
    check("rd_idle_grant", {30'd0, grant_o}, 32'd0);
    tick();
    check("stray_ack_sreq", {31'd0, s_req_o}, 32'd0);
    check("stray_ack_noack", {31'd0, m0_ack | m1_ack}, 32'd0);
    s_ack = 1'b0; s_rdata = 32'd0;

    // Read formatting and write ack.
    xact("m1_byte_s", 1, 1'b0, 4'b0001, 1'b1, 32'h0000_0080, 32'hFFFF_FF80);
    xact("m1_byte_u", 1, 1'b0, 4'b0001, 1'b0, 32'h0000_0080, 32'h0000_0080);
    xact("m0_half_s", 0, 1'b0, 4'b0011, 1'b1, 32'h1234_8001, 32'hFFFF_8001);
    xact("m0_half_u", 0, 1'b0, 4'b0011, 1'b0, 32'h1234_8001, 32'h0000_8001);
    xact("m0_badmask", 0, 1'b0, 4'b0101, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    xact("m1_write", 1, 1'b1, 4'b1111, 1'b0, 32'hCAFE_F00D, 32'h0000_0000);

    // Both masters requesting continuously, immediate slave ack.
    m0_req = 1'b1; m0_we = 1'b0; m0_byte_mask = 4'hF; m0_load_sign = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_byte_mask = 4'hF; m1_load_sign = 1'b0;
    s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rot_grant%0d", i), {30'd0, grant_o}, (i % 5 == 4) ? 32'd2 : 32'd1);
      tick();
      check($sformatf("rot_ack%0d", i), {30'd0, m1_ack, m0_ack}, (i % 5 == 4) ? 32'd2 : 32'd1);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0; s_rdata = 32'd0;

    // m0 write with no slave response: 16 BUSY cycles, then err.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hA5A5A5A5; m0_byte_mask = 4'hF;
    tick();
    check("to_rw", {31'd0, s_rw_o}, 32'd1);
    check("to_wdata", s_wdata_o, 32'hA5A5A5A5);
    check("to_addr", s_addr_o, 32'h20);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_sreq%0d", i), {30'd0, m0_err, s_req_o}, 32'd1);
      if (i < 15) tick();
    end
    tick();
    check("to_sreq_drop", {31'd0, s_req_o}, 32'd0);
    check("to_err", {31'd0, m0_err}, 32'd1);
    check("to_noack", {29'd0, m0_ack, m1_ack, m1_err}, 32'd0);
    m0_req = 1'b0;
    tick();
    check("to_err_once", {31'd0, m0_err}, 32'd0);
    check("to_idle", {30'd0, grant_o}, 32'd0);

    // Reset in the second BUSY cycle wins over s_ack.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300; m0_wdata = 32'h77; m0_byte_mask = 4'hF;
    tick();
    tick();
    check("rb_busy", {31'd0, s_req_o}, 32'd1);
    rst = 1'b1; s_ack = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    check_all_zero("rst_busy");
    rst = 1'b0; m0_req = 1'b0; s_ack = 1'b0;
    tick();
    check("rb_idle", {28'd0, s_req_o, m0_ack, grant_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
